// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and geometry for the conv window feeder
package conv_pkg;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 9;
    localparam int IMG_H  = 9;
    localparam int K      = 3;
    localparam int STRIDE = 2;
    localparam int ADDR_W = 10;

    typedef logic signed [DATA_W-1:0] pixel_t;

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    localparam int OUT_W   = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H   = out_dim(IMG_H, K, STRIDE);
    localparam int N_BEATS = OUT_H * OUT_W * K;
endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - col/window counters and the three row-port read addresses
module conv_addr_gen
    import conv_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_advance,
    input  logic                   i_clear,
    output logic                   o_first,
    output logic                   o_last,
    output logic                   o_final,
    output logic [2:0][ADDR_W-1:0] o_addr
);
    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] WX_MAX   = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] WY_MAX   = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW      = ADDR_W'(IMG_W);

    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_wx;
    logic [ADDR_W-1:0] r_wy;
    logic [ADDR_W-1:0] w_top;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_col <= '0;
            r_wx  <= '0;
            r_wy  <= '0;
        end else if (i_advance) begin
            if (r_col == COL_MAX) begin
                r_col <= '0;
                if (r_wx == WX_MAX) begin
                    r_wx <= '0;
                    r_wy <= (r_wy == WY_MAX) ? '0 : r_wy + 1'b1;
                end else begin
                    r_wx <= r_wx + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Rows below the top one are fixed offsets of whole image lines.
    assign w_top     = r_wy * ROW_STEP + r_wx * COL_STEP + r_col;
    assign o_addr[2] = w_top;
    assign o_addr[1] = w_top + ROW;
    assign o_addr[0] = w_top + ROW + ROW;

    assign o_first = (r_col == '0);
    assign o_last  = (r_col == COL_MAX);
    assign o_final = o_last && (r_wx == WX_MAX) && (r_wy == WY_MAX);
endmodule

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - walks the feature map and emits KxK windows as column beats
module conv_window_feeder
    import conv_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [2:0][ADDR_W-1:0] ram_addr,
    input  pixel_t [2:0]           ram_data,
    output pixel_t [2:0]           inputData,
    output logic                   valid,
    output logic                   win_first,
    output logic                   win_last,
    output logic [ADDR_W-1:0]      rAddr,
    output logic                   busy,
    output logic                   done
);
    if ((IMG_W * IMG_H > 2 ** ADDR_W) || (K != 3)) begin : g_geom_chk
        $error("conv_window_feeder: map does not fit ADDR_W or K is not 3");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_drain;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_W-1:0]       r_beat_cnt;
    logic                    w_run;
    logic                    w_clear;
    logic                    w_first;
    logic                    w_last;
    logic                    w_final;
    logic [2:0][ADDR_W-1:0]  w_addr;

    logic                    r_s1_valid;
    logic                    r_s1_first;
    logic                    r_s1_last;
    logic [ADDR_W-1:0]       r_s1_cnt;
    logic                    r_valid;
    logic                    r_first;
    logic                    r_last;
    logic [ADDR_W-1:0]       r_raddr;
    pixel_t [2:0]            r_data;

    assign w_run   = (r_state == S_RUN);
    assign w_clear = (r_state == S_IDLE) && start;

    conv_addr_gen u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .i_advance (w_run),
        .i_clear   (w_clear),
        .o_first   (w_first),
        .o_last    (w_last),
        .o_final   (w_final),
        .o_addr    (w_addr)
    );

    assign ram_addr = w_run ? w_addr : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_drain    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (w_final) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_drain <= ~r_drain;
                    if (r_drain) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Framing rides two stages so it lines up with the RAM read plus output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cnt   <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_raddr    <= '0;
            r_data     <= '0;
        end else begin
            r_s1_valid <= w_run;
            r_s1_first <= w_run && w_first;
            r_s1_last  <= w_run && w_last;
            r_s1_cnt   <= w_run ? r_beat_cnt + 1'b1 : '0;
            r_valid    <= r_s1_valid;
            r_first    <= r_s1_first;
            r_last     <= r_s1_last;
            r_raddr    <= r_s1_cnt;
            if (r_s1_valid) begin
                r_data <= ram_data;
            end
        end
    end

    assign inputData = r_data;
    assign valid     = r_valid;
    assign win_first = r_first;
    assign win_last  = r_last;
    assign rAddr     = r_raddr;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - directed self-checking bench for conv_window_feeder
module tb_conv_window_feeder;
    logic              clock;
    logic              reset;
    logic              start;
    logic [2:0][9:0]   ram_addr;
    logic [2:0][15:0]  ram_data;
    logic [2:0][15:0]  inputData;
    logic              valid;
    logic              win_first;
    logic              win_last;
    logic [9:0]        rAddr;
    logic              busy;
    logic              done;

    int tests_run;
    int tests_failed;

    logic [47:0] cap_data  [1:64];
    logic        cap_first [1:64];
    logic        cap_last  [1:64];
    logic [9:0]  cap_raddr [1:64];
    int n_valid, n_first, n_last, n_done, n_gap, n_idle_bad;
    int first_valid_cyc, last_valid_cyc, done_cyc;
    logic done_valid, done_busy;
    logic [9:0] done_raddr;
    logic busy_after, busy_at0;

    conv_window_feeder dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .inputData (inputData),
        .valid     (valid),
        .win_first (win_first),
        .win_last  (win_last),
        .rAddr     (rAddr),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM with word[a] = a and one cycle of read latency
    always @(posedge clock) begin
        ram_data[2] <= 16'(ram_addr[2]);
        ram_data[1] <= 16'(ram_addr[1]);
        ram_data[0] <= 16'(ram_addr[0]);
    end

    function automatic logic [47:0] exp_beat(input int b);
        int w, col, wx, wy, top;
        w   = (b - 1) / 3;
        col = (b - 1) % 3;
        wy  = w / 4;
        wx  = w % 4;
        top = wy * 18 + wx * 2 + col;
        return {16'(top), 16'(top + 9), 16'(top + 18)};
    endfunction

    // Pulses start, then records every sampled cycle until a few cycles past done.
    task automatic run_pass(input int poke_at, input bit poke_done);
        n_valid = 0; n_first = 0; n_last = 0; n_done = 0; n_gap = 0; n_idle_bad = 0;
        first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
        done_valid = 1'bx; done_busy = 1'bx; done_raddr = 'x; busy_after = 1'bx;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        busy_at0 = busy;
        for (int cyc = 0; cyc < 200; cyc++) begin
            start = 1'b0;
            if (valid) begin
                n_valid++;
                if (n_valid > 1 && last_valid_cyc != cyc - 1) n_gap++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
                if (n_valid <= 64) begin
                    cap_data[n_valid]  = inputData;
                    cap_first[n_valid] = win_first;
                    cap_last[n_valid]  = win_last;
                    cap_raddr[n_valid] = rAddr;
                end
                if (win_first) n_first++;
                if (win_last) n_last++;
                if (poke_at > 0 && n_valid == poke_at) start = 1'b1;
            end else if (win_first || win_last || rAddr != 0) begin
                n_idle_bad++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc   = cyc;
                    done_valid = valid;
                    done_busy  = busy;
                    done_raddr = rAddr;
                end
                if (poke_done) start = 1'b1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 4) begin
                busy_after = busy;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid); end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        tests_run++;
        if (ram_addr !== 30'd0) begin tests_failed++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        tests_run++;
        if (inputData !== 48'd0) begin tests_failed++; $display("FAIL reset_data got %h want 0", inputData); end
        tests_run++;
        if (rAddr !== 10'd0 || win_first !== 1'b0 || win_last !== 1'b0) begin
            tests_failed++; $display("FAIL reset_framing got rAddr=%0d f=%b l=%b want 0", rAddr, win_first, win_last);
        end
    endtask

    task automatic test_first_beat;
        run_pass(0, 1'b0);
        tests_run++;
        if (busy_at0 !== 1'b1) begin tests_failed++; $display("FAIL first_busy got %b want 1", busy_at0); end
        tests_run++;
        if (first_valid_cyc != 2) begin tests_failed++; $display("FAIL first_latency got %0d want 2", first_valid_cyc); end
        tests_run++;
        if (cap_data[1] !== {16'd0, 16'd9, 16'd18}) begin tests_failed++; $display("FAIL first_data got %h want 0/9/18", cap_data[1]); end
        tests_run++;
        if (cap_first[1] !== 1'b1 || cap_last[1] !== 1'b0 || cap_raddr[1] !== 10'd1) begin
            tests_failed++; $display("FAIL first_framing got f=%b l=%b r=%0d want f=1 l=0 r=1", cap_first[1], cap_last[1], cap_raddr[1]);
        end
    endtask

    task automatic test_window_step;
        tests_run++;
        if (cap_data[3] !== {16'd2, 16'd11, 16'd20} || cap_last[3] !== 1'b1) begin
            tests_failed++; $display("FAIL beat3 got %h l=%b want 2/11/20 l=1", cap_data[3], cap_last[3]);
        end
        tests_run++;
        if (cap_data[4] !== {16'd2, 16'd11, 16'd20} || cap_first[4] !== 1'b1 || cap_raddr[4] !== 10'd4) begin
            tests_failed++; $display("FAIL beat4 got %h f=%b r=%0d want 2/11/20 f=1 r=4", cap_data[4], cap_first[4], cap_raddr[4]);
        end
        tests_run++;
        if (cap_data[13] !== {16'd18, 16'd27, 16'd36} || cap_first[13] !== 1'b1) begin
            tests_failed++; $display("FAIL beat13 got %h f=%b want 18/27/36 f=1", cap_data[13], cap_first[13]);
        end
    endtask

    task automatic test_final_beat;
        tests_run++;
        if (cap_data[48] !== {16'd62, 16'd71, 16'd80} || cap_last[48] !== 1'b1 || cap_raddr[48] !== 10'd48) begin
            tests_failed++; $display("FAIL beat48 got %h l=%b r=%0d want 62/71/80 l=1 r=48", cap_data[48], cap_last[48], cap_raddr[48]);
        end
        tests_run++;
        if (done_cyc != last_valid_cyc + 1) begin tests_failed++; $display("FAIL done_timing got %0d want %0d", done_cyc, last_valid_cyc + 1); end
        tests_run++;
        if (done_valid !== 1'b0 || done_busy !== 1'b0 || done_raddr !== 10'd0) begin
            tests_failed++; $display("FAIL done_cycle got v=%b b=%b r=%0d want 0 0 0", done_valid, done_busy, done_raddr);
        end
    endtask

    task automatic test_counts;
        tests_run++;
        if (n_valid != 48 || n_gap != 0) begin tests_failed++; $display("FAIL valid_count got %0d gaps=%0d want 48 gaps=0", n_valid, n_gap); end
        tests_run++;
        if (n_first != 16 || n_last != 16) begin tests_failed++; $display("FAIL frame_count got f=%0d l=%0d want 16 16", n_first, n_last); end
        tests_run++;
        if (n_done != 1 || n_idle_bad != 0) begin tests_failed++; $display("FAIL done_idle got done=%0d idlebad=%0d want 1 0", n_done, n_idle_bad); end
    endtask

    task automatic test_restart_ignored;
        int bad;
        run_pass(20, 1'b1);
        bad = 0;
        for (int b = 1; b <= 48; b++) begin
            if (cap_data[b] !== exp_beat(b) || cap_raddr[b] !== 10'(b)) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL restart_sequence got %0d bad beats want 0", bad); end
        tests_run++;
        if (n_valid != 48 || n_done != 1) begin tests_failed++; $display("FAIL restart_counts got v=%0d d=%0d want 48 1", n_valid, n_done); end
        tests_run++;
        if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL restart_after_done got busy=%b want 0", busy_after); end
    endtask

    task automatic test_reset_mid_pass;
        int found, n_late_done, n_late_valid;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (valid && rAddr == 10'd30) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (found != 1) begin tests_failed++; $display("FAIL rst_reach_beat30 got %0d want 1", found); end
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_flags got v=%b b=%b d=%b want 000", valid, busy, done);
        end
        tests_run++;
        if (ram_addr !== 30'd0 || inputData !== 48'd0 || rAddr !== 10'd0) begin
            tests_failed++; $display("FAIL rst_mid_outputs got a=%h d=%h r=%0d want 0", ram_addr, inputData, rAddr);
        end
        reset = 1'b0;
        n_late_done = 0;
        n_late_valid = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clock);
            if (done) n_late_done++;
            if (valid) n_late_valid++;
        end
        tests_run++;
        if (n_late_done != 0 || n_late_valid != 0) begin
            tests_failed++; $display("FAIL rst_no_done got d=%0d v=%0d want 0 0", n_late_done, n_late_valid);
        end
        run_pass(0, 1'b0);
        tests_run++;
        if (first_valid_cyc != 2 || cap_data[1] !== {16'd0, 16'd9, 16'd18} || cap_raddr[1] !== 10'd1) begin
            tests_failed++; $display("FAIL rst_fresh_pass got cyc=%0d d=%h r=%0d want 2 0/9/18 1", first_valid_cyc, cap_data[1], cap_raddr[1]);
        end
        tests_run++;
        if (n_valid != 48 || n_done != 1) begin tests_failed++; $display("FAIL rst_fresh_counts got v=%0d d=%0d want 48 1", n_valid, n_done); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_first_beat();
        test_window_step();
        test_final_beat();
        test_counts();
        test_restart_ignored();
        test_reset_mid_pass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
